// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with start/pause control, borrow output for
// cascading and a one-cycle done pulse on expiry.
module down_counter_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_in,
  input  logic             load,
  input  logic             start,
  input  logic             pause,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             b_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] HOLD = 2'b10;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (load) begin
      count_d = load_in;
      // A zero preset while running ends the countdown silently.
      if (state_q == RUN && load_in == '0) state_d = IDLE;
      else if (state_q != RUN && state_q != HOLD) state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!pause && start) begin
            if (count_q != '0) state_d = RUN;
            else               done_d  = 1'b1;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = HOLD;
          end else if (enable) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else if (count_q == ONE) begin
              count_d = '0;
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        HOLD: begin
          if (start && !pause) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign done  = done_q;
  assign busy  = (state_q == RUN) || (state_q == HOLD);
  assign b_out = (state_q == RUN) && (count_q == ONE) && enable && !load && !pause;

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed scenarios plus a
// randomized run against a behavioural timer model.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] load_in = '0;
  logic       load = 1'b0, start = 1'b0, pause = 1'b0, enable = 1'b0;
  logic [7:0] count;
  logic       b_out, busy, done;

  logic       reset4 = 1'b0;
  logic [3:0] load_in4 = '0;
  logic       load4 = 1'b0, start4 = 1'b0, enable4 = 1'b0;
  logic [3:0] count4;
  logic       b_out4, busy4, done4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  down_counter_timer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .load_in(load_in), .load(load), .start(start),
    .pause(pause), .enable(enable), .count(count), .b_out(b_out),
    .busy(busy), .done(done)
  );

  down_counter_timer #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset4), .load_in(load_in4), .load(load4), .start(start4),
    .pause(1'b0), .enable(enable4), .count(count4), .b_out(b_out4),
    .busy(busy4), .done(done4)
  );

  // Drive inputs mid-cycle, then let the caller inspect combinational outputs.
  task automatic set_in(input bit ld, input logic [7:0] lin, input bit st,
                        input bit pa, input bit en);
    @(negedge clk);
    load = ld; load_in = lin; start = st; pause = pa; enable = en;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    load = 0; start = 0; pause = 0; enable = 0; load_in = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    tests++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || b_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: count=%0d busy=%b done=%b b_out=%b, want 0/0/0/0",
               count, busy, done, b_out);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_countdown();
    int exp_cnt [4] = '{3, 2, 1, 0};
    do_reset();
    set_in(1, 8'd3, 0, 0, 0); step();
    set_in(0, 8'd0, 1, 0, 0); step();
    tests++;
    if (count !== 8'd3 || busy !== 1'b1) begin
      fails++;
      $display("FAIL countdown_start: count=%0d busy=%b, want 3/1", count, busy);
    end
    for (int i = 1; i < 4; i++) begin
      set_in(0, 8'd0, 0, 0, 1);
      tests++;
      if (b_out !== (exp_cnt[i-1] == 1)) begin
        fails++;
        $display("FAIL countdown_bout[%0d]: b_out=%b, want %b", i, b_out, exp_cnt[i-1] == 1);
      end
      step();
      tests++;
      if (count !== 8'(exp_cnt[i]) || done !== (i == 3) || busy !== (i != 3)) begin
        fails++;
        $display("FAIL countdown_step[%0d]: count=%0d done=%b busy=%b, want %0d/%b/%b",
                 i, count, done, busy, exp_cnt[i], i == 3, i != 3);
      end
    end
    set_in(0, 8'd0, 0, 0, 1); step();
    tests++;
    if (done !== 1'b0 || count !== 8'd0) begin
      fails++;
      $display("FAIL countdown_after: done=%b count=%0d, want 0/0", done, count);
    end
  endtask

  task automatic test_pause();
    do_reset();
    set_in(1, 8'd5, 0, 0, 0); step();
    set_in(0, 8'd0, 1, 0, 0); step();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 8'd0, 0, 1, 1);
      tests++;
      if (b_out !== 1'b0) begin
        fails++;
        $display("FAIL pause_bout[%0d]: b_out=%b, want 0", i, b_out);
      end
      step();
      tests++;
      if (count !== 8'd5 || busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL pause_hold[%0d]: count=%0d busy=%b done=%b, want 5/1/0", i, count, busy, done);
      end
    end
    set_in(0, 8'd0, 0, 0, 1); step();
    tests++;
    if (count !== 8'd5) begin
      fails++;
      $display("FAIL pause_ignores_enable: count=%0d, want 5", count);
    end
    set_in(0, 8'd0, 1, 0, 0); step();
    set_in(0, 8'd0, 0, 0, 1); step();
    tests++;
    if (count !== 8'd4 || busy !== 1'b1) begin
      fails++;
      $display("FAIL pause_resume: count=%0d busy=%b, want 4/1", count, busy);
    end
  endtask

  task automatic test_zero_start();
    do_reset();
    set_in(0, 8'd0, 1, 0, 1); step();
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== 8'd0) begin
      fails++;
      $display("FAIL zero_start: done=%b busy=%b count=%0d, want 1/0/0", done, busy, count);
    end
    set_in(0, 8'd0, 0, 0, 1); step();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_start_after: done=%b busy=%b, want 0/0", done, busy);
    end
  endtask

  task automatic test_load_override();
    do_reset();
    set_in(1, 8'd2, 0, 0, 0); step();
    set_in(0, 8'd0, 1, 0, 0); step();
    set_in(0, 8'd0, 0, 0, 1); step();
    set_in(1, 8'd7, 0, 0, 1);
    tests++;
    if (b_out !== 1'b0) begin
      fails++;
      $display("FAIL load_override_bout: b_out=%b, want 0", b_out);
    end
    step();
    tests++;
    if (count !== 8'd7 || done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL load_override: count=%0d done=%b busy=%b, want 7/0/1", count, done, busy);
    end
    set_in(0, 8'd0, 0, 0, 1); step();
    tests++;
    if (count !== 8'd6) begin
      fails++;
      $display("FAIL load_override_run: count=%0d, want 6", count);
    end
    set_in(1, 8'd0, 0, 0, 1); step();
    tests++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL load_zero_run: count=%0d busy=%b done=%b, want 0/0/0", count, busy, done);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_in(1, 8'd9, 0, 0, 0); step();
    set_in(0, 8'd0, 1, 0, 0); step();
    @(negedge clk);
    start = 0;
    #2 reset = 1'b1;
    #1;
    tests++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || b_out !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: count=%0d busy=%b done=%b b_out=%b, want 0/0/0/0",
               count, busy, done, b_out);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(0, 8'd0, 0, 0, 1); step();
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || count !== 8'd0) begin
        fails++;
        $display("FAIL async_reset_after[%0d]: done=%b busy=%b count=%0d, want 0/0/0",
                 i, done, busy, count);
      end
    end
  endtask

  task automatic test_width4();
    int exp_c = 15;
    int decs = 0;
    int prev;
    bit wrapped = 0;
    bit exp_done;
    @(negedge clk); reset4 = 1'b1;
    @(negedge clk); reset4 = 1'b0; load4 = 1; load_in4 = 4'd15;
    @(negedge clk); load4 = 0; start4 = 1;
    @(negedge clk); start4 = 0;
    prev = int'(count4);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      enable4 = (i % 2 == 0);
      exp_done = 0;
      if (enable4 && exp_c > 0) begin
        exp_c--;
        exp_done = (exp_c == 0);
      end
      @(posedge clk); #1;
      if (int'(count4) == prev - 1) decs++;
      if (int'(count4) > prev) wrapped = 1;
      prev = int'(count4);
      tests++;
      if (int'(count4) != exp_c || done4 !== exp_done) begin
        fails++;
        $display("FAIL width4_step[%0d]: count=%0d done=%b, want %0d/%b", i, count4, done4, exp_c, exp_done);
      end
    end
    enable4 = 0;
    tests++;
    if (decs != 15 || wrapped || count4 !== 4'd0 || busy4 !== 1'b0) begin
      fails++;
      $display("FAIL width4_total: decs=%0d wrapped=%b count=%0d busy=%b, want 15/0/0/0",
               decs, wrapped, count4, busy4);
    end
  endtask

  // Behavioural model: timer is idle, running or held; count only moves while running.
  task automatic test_random();
    int  m_cnt = 0;
    bit  m_run = 0, m_hold = 0, m_done = 0;
    bit  ld, st, pa, en, exp_b;
    logic [7:0] lin;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ld  = ($urandom % 8) == 0;
      lin = ($urandom % 2) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      st  = ($urandom % 3) == 0;
      pa  = ($urandom % 6) == 0;
      en  = ($urandom % 2) == 0;
      set_in(ld, lin, st, pa, en);
      exp_b = m_run && m_cnt == 1 && en && !ld && !pa;
      tests++;
      if (b_out !== exp_b) begin
        fails++;
        $display("FAIL random_bout[%0d]: b_out=%b, want %b", i, b_out, exp_b);
      end
      m_done = 0;
      if (ld) begin
        m_cnt = int'(lin);
        if (m_run && m_cnt == 0) m_run = 0;
      end else if (m_run) begin
        if (pa) begin
          m_run = 0; m_hold = 1;
        end else if (en && m_cnt > 0) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin m_run = 0; m_done = 1; end
        end
      end else if (m_hold) begin
        if (st && !pa) begin m_hold = 0; m_run = 1; end
      end else if (st && !pa) begin
        if (m_cnt != 0) m_run = 1;
        else            m_done = 1;
      end
      step();
      tests++;
      if (int'(count) != m_cnt || busy !== (m_run || m_hold) || done !== m_done) begin
        fails++;
        $display("FAIL random_state[%0d]: count=%0d busy=%b done=%b, want %0d/%b/%b",
                 i, count, busy, done, m_cnt, m_run || m_hold, m_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_zero_start();
    test_load_override();
    test_async_reset();
    test_width4();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
